// File: rtl/rob_retire.sv
// In-order reorder buffer: accepts renamed uops, marks them done from ring
// broadcasts or tag completions, retires one per cycle and tracks the committed map.
module rob_retire #(
    parameter int ARCHFILE_SIZE = 32,
    parameter int PHYSFILE_SIZE = 256,
    parameter int ROB_SIZE      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             disp_valid,
    input  logic [$clog2(ARCHFILE_SIZE)-1:0] disp_arch_wr,
    input  logic [$clog2(PHYSFILE_SIZE)-1:0] disp_phys_wr,
    output logic                             disp_ready,
    output logic [$clog2(ROB_SIZE)-1:0]      disp_tag,
    input  logic                             ring_update,
    input  logic [$clog2(PHYSFILE_SIZE)-1:0] phys_ring,
    input  logic                             ring_exc,
    input  logic                             cmp_valid,
    input  logic [$clog2(ROB_SIZE)-1:0]      cmp_tag,
    input  logic                             cmp_exc,
    output logic                             rob_update,
    output logic [$clog2(ARCHFILE_SIZE)-1:0] arch_rob_update,
    output logic [$clog2(PHYSFILE_SIZE)-1:0] arch_rob_nonspec_phys,
    output logic [$clog2(PHYSFILE_SIZE)-1:0] phys_rob_free,
    output logic                             rollback,
    output logic                             rob_full,
    output logic                             rob_empty,
    output logic [$clog2(ROB_SIZE):0]        rob_count
);

    localparam int AW = $clog2(ARCHFILE_SIZE);
    localparam int PW = $clog2(PHYSFILE_SIZE);
    localparam int TW = $clog2(ROB_SIZE);
    localparam int CW = TW + 1;

    typedef struct packed {
        logic          valid;
        logic          done;
        logic          exc;
        logic [AW-1:0] arch_wr;
        logic [PW-1:0] phys_wr;
    } entry_t;

    entry_t        rob_q  [ROB_SIZE];
    logic [PW-1:0] cmap_q [ARCHFILE_SIZE];
    logic [TW-1:0] head_q;
    logic [TW-1:0] tail_q;
    logic [CW-1:0] count_q;

    entry_t              head_entry;
    logic                disp_fire;
    logic                retire_ok;
    logic                retire_fault;
    logic                retire_write;
    logic [ROB_SIZE-1:0] ring_hit;
    logic [ROB_SIZE-1:0] cmp_hit;

    // Status is derived from the registered count only, so full/empty never
    // depend on pointer equality and disp_ready has no input-to-output path.
    assign rob_full   = (count_q == CW'(ROB_SIZE));
    assign rob_empty  = (count_q == '0);
    assign rob_count  = count_q;
    assign disp_ready = !rob_full;
    assign disp_tag   = tail_q;

    assign head_entry   = rob_q[head_q];
    assign disp_fire    = disp_valid && !rob_full;
    assign retire_ok    = head_entry.valid && head_entry.done && !head_entry.exc;
    assign retire_fault = head_entry.valid && head_entry.done && head_entry.exc;
    assign retire_write = retire_ok && (head_entry.arch_wr != '0);

    // Only entries already valid before this edge can match, so a uop being
    // dispatched right now never picks up a broadcast in the same cycle.
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            ring_hit[i] = ring_update && rob_q[i].valid && (rob_q[i].arch_wr != '0) &&
                          (rob_q[i].phys_wr == phys_ring);
            cmp_hit[i]  = cmp_valid && rob_q[i].valid && (cmp_tag == TW'(i));
        end
    end

    // NOTE: the entry array is small enough to reset outright; this keeps
    // stale done/exc bits from ever being observed after a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                rob_q[i] <= '0;
            end
        end else if (retire_fault) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                rob_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (ring_hit[i] || cmp_hit[i]) begin
                    rob_q[i].done <= 1'b1;
                    rob_q[i].exc  <= rob_q[i].exc | (ring_hit[i] & ring_exc) |
                                     (cmp_hit[i] & cmp_exc);
                end
            end
            if (retire_ok) begin
                rob_q[head_q].valid <= 1'b0;
            end
            if (disp_fire) begin
                rob_q[tail_q] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0,
                                   arch_wr: disp_arch_wr, phys_wr: disp_phys_wr};
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every block
    // sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (retire_fault) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (retire_ok) begin
                head_q <= head_q + TW'(1);
            end
            if (disp_fire) begin
                tail_q <= tail_q + TW'(1);
            end
            count_q <= count_q + CW'(disp_fire) - CW'(retire_ok);
        end
    end

    // Committed map and retire outputs; data outputs hold between retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_update            <= 1'b0;
            rollback              <= 1'b0;
            arch_rob_update       <= '0;
            arch_rob_nonspec_phys <= '0;
            phys_rob_free         <= '0;
            for (int i = 0; i < ARCHFILE_SIZE; i++) begin
                cmap_q[i] <= PW'(i);
            end
        end else begin
            rob_update <= retire_write;
            rollback   <= retire_fault;
            if (retire_write) begin
                arch_rob_update            <= head_entry.arch_wr;
                arch_rob_nonspec_phys      <= head_entry.phys_wr;
                phys_rob_free              <= cmap_q[head_entry.arch_wr];
                cmap_q[head_entry.arch_wr] <= head_entry.phys_wr;
            end
        end
    end

    update_rollback_exclusive: assert property (
        @(posedge clk) disable iff (!rst) !(rob_update && rollback));

    count_in_range: assert property (
        @(posedge clk) disable iff (!rst) count_q <= CW'(ROB_SIZE));

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- Reorder buffer feeding the commit-side inputs of the rename/register file: `rob_update`, `arch_rob_update`, `arch_rob_nonspec_phys`, `phys_rob_free` and `rollback`.
- Accepts renamed uops in program order and marks them done from ring broadcasts or tag completions.
- Retires at most one uop per cycle, in order.
- Keeps the committed arch-to-phys map so each retire can name the physical register to free.
- A faulting head flushes the ROB and raises `rollback`.

Parameters:
- ARCHFILE_SIZE, 32, number of architectural registers
- PHYSFILE_SIZE, 256, number of physical registers
- ROB_SIZE, 16, number of entries; power of two

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- disp_valid  in  1  dispatch a uop this cycle
- disp_arch_wr  in  log2(ARCHFILE_SIZE)  destination arch reg; 0 = no destination
- disp_phys_wr  in  log2(PHYSFILE_SIZE)  allocated phys reg (`phys_wr` from regfile); ignored when disp_arch_wr==0
- disp_ready  out  1  ROB can accept a dispatch (registered, = !rob_full)
- disp_tag  out  log2(ROB_SIZE)  index the current dispatch will occupy (= tail)
- ring_update  in  1  result broadcast valid
- phys_ring  in  log2(PHYSFILE_SIZE)  phys reg written by the broadcast
- ring_exc  in  1  broadcast uop faulted
- cmp_valid  in  1  completion for a no-destination uop (branch/store)
- cmp_tag  in  log2(ROB_SIZE)  ROB index completing
- cmp_exc  in  1  completing uop faulted or mispredicted
- rob_update  out  1  one-cycle retire pulse to regfile
- arch_rob_update  out  log2(ARCHFILE_SIZE)  retired arch reg
- arch_rob_nonspec_phys  out  log2(PHYSFILE_SIZE)  new committed phys for that arch reg
- phys_rob_free  out  log2(PHYSFILE_SIZE)  previously committed phys, returned to free list
- rollback  out  1  one-cycle flush pulse
- rob_full  out  1  count==ROB_SIZE
- rob_empty  out  1  count==0
- rob_count  out  log2(ROB_SIZE)+1  occupancy

Behaviour:
- Reset (rst low, async):
  - all entries invalid; head=tail=0; count=0.
  - committed map entry i = i for all i.
  - rob_update=0, rollback=0, all data outputs 0.
  - rob_empty=1, rob_full=0, disp_ready=1.
- Entry fields: valid, done, exc, arch_wr, phys_wr.
- Dispatch:
  - when disp_valid && disp_ready at the edge, write the entry at tail with done=0 and exc=0, then advance tail (mod ROB_SIZE).
  - disp_valid while !disp_ready: ignored, no state change.
  - A dispatch with arch_wr==0 never matches the ring.
- Ring completion:
  - every valid entry with arch_wr!=0 and phys_wr==phys_ring gets done=1 and exc|=ring_exc.
  - An entry written by a dispatch in the same cycle is not matched.
- Tag completion: if cmp_valid and entry[cmp_tag] is valid, set done=1 and exc|=cmp_exc. A completion to an invalid entry is ignored.
- Ring and tag completions in the same cycle both apply, including to the same entry (flags OR).
- Retire is evaluated at each edge on registered head state. Outputs are registered, so an entry done at edge E is visible on rob_update during the cycle after edge E+1.
- Normal retire (head valid, done, !exc):
  - pop head; head++, count--.
  - If arch_wr!=0: rob_update=1, arch_rob_update=arch_wr, arch_rob_nonspec_phys=phys_wr, phys_rob_free=cmap[arch_wr]; then cmap[arch_wr]<=phys_wr.
  - If arch_wr==0: pop only; rob_update=0.
- Faulting retire (head done && exc):
  - no rob_update; rollback=1 for exactly one cycle.
  - all entries invalidated; head=tail=0; count=0; cmap unchanged.
  - Dispatch and completions presented in the same cycle are discarded.
  - Speculative phys regs are reclaimed by the regfile on rollback, not by this block.
- rob_update and rollback are never high together; both deassert the cycle after.
- Simultaneous dispatch and retire: count unchanged. When full, disp_ready stays low that cycle; no bypass.
- Pointer wrap: index ROB_SIZE-1 is followed by 0. full/empty are derived from count, never from pointer equality.
- Reset asserted mid-operation: immediate return to reset state, including cmap=identity.

Test Plan:
- Reset then dispatch (arch 5, phys 40), ring phys_ring=40 -> two cycles later rob_update=1, arch_rob_update=5, nonspec_phys=40, phys_rob_free=5; a second write to arch 5 (phys 41) frees 40.
- Out-of-order completion: dispatch A(arch 1, phys 32), B(arch 2, phys 33); ring 33 then 32 -> retire order A then B on consecutive cycles; rob_count goes 2,1,0.
- Fill 16 entries -> rob_full=1, disp_ready=0; 17th dispatch ignored. Retire one, then dispatch -> tail wraps to 0, disp_tag=0.
- No-dest uop: dispatch arch 0 at tag 3, cmp_valid with cmp_tag=3 -> entry popped, rob_update stays 0.
- Fault: head tag 0 completes with cmp_exc=1 while 4 younger entries are valid -> rollback=1 for one cycle, rob_empty=1, tail=0, cmap unchanged (phys_rob_free on the next arch-7 retire returns the pre-fault mapping).
- Assert rst low mid-fill with count=9 -> outputs zero and rob_empty=1 immediately, without a clock edge; cmap resets to identity.
